// File: rtl/dot_product_acc.sv
// dot_product_acc: signed 32x32 multiply-accumulate stage.
// It accepts BURST_LEN operand pairs over a valid/ready handshake and returns
// their ACC_W-bit signed sum on a held output handshake.
// The path is: operand register, Wallace multiplier, product register,
// then accumulator.
// Optional build macro DPACC_SAT_EN: saturate the running sum on signed
// overflow instead of wrapping. ovf reports the event in both builds.

// wallace_mul_32bit: combinational signed 32x32 -> 64 multiplier built as a
// carry-save (3:2 compressor) reduction tree over 33 partial-product rows.
module wallace_mul_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);
    localparam int ROWS0  = 33;
    localparam int LEVELS = 8;

    // Number of rows alive at a given tree level (each full triple becomes two rows).
    function automatic int rows_at(input int lvl);
        int n;
        n = ROWS0;
        for (int k = 0; k < lvl; k++) begin
            n = (n / 3) * 2 + (n % 3);
        end
        return n;
    endfunction

    logic [63:0] a_ext_s;
    logic [63:0] tree_s [0:LEVELS][0:ROWS0-1];

    assign a_ext_s = {{32{a[31]}}, a};

    // Partial products plus the carry-save reduction, level by level, down to two rows.
    always_comb begin
        int          np;
        int          grp;
        int          rem;
        logic [63:0] x_v;
        logic [63:0] y_v;
        logic [63:0] z_v;
        for (int l = 0; l <= LEVELS; l++) begin
            for (int r = 0; r < ROWS0; r++) begin
                tree_s[l][r] = 64'd0;
            end
        end
        // Rows 0..30 are positive weights. The sign bit of b carries a weight of -2^31.
        // That row is stored as its one's complement, with the +1 placed on row 32.
        for (int i = 0; i < 31; i++) begin
            tree_s[0][i] = b[i] ? (a_ext_s << i) : 64'd0;
        end
        tree_s[0][31] = b[31] ? ~(a_ext_s << 31) : 64'd0;
        tree_s[0][32] = {63'd0, b[31]};
        for (int l = 1; l <= LEVELS; l++) begin
            np  = rows_at(l - 1);
            grp = np / 3;
            rem = np % 3;
            for (int g = 0; g < ROWS0 / 3; g++) begin
                if (g < grp) begin
                    x_v = tree_s[l-1][3*g];
                    y_v = tree_s[l-1][3*g+1];
                    z_v = tree_s[l-1][3*g+2];
                    tree_s[l][2*g]   = x_v ^ y_v ^ z_v;
                    tree_s[l][2*g+1] = ((x_v & y_v) | (x_v & z_v) | (y_v & z_v)) << 1;
                end else begin
                    tree_s[l][2*g]   = 64'd0;
                    tree_s[l][2*g+1] = 64'd0;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < rem) begin
                    tree_s[l][2*grp+r] = tree_s[l-1][3*grp+r];
                end else begin
                    tree_s[l][2*grp+r] = 64'd0;
                end
            end
        end
    end

    assign product = tree_s[LEVELS][0] + tree_s[LEVELS][1];
endmodule

module dot_product_acc #(
    parameter int BURST_LEN = 4,   // products per result, 1..255
    parameter int ACC_W     = 64   // accumulator/result width, >= 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   add_cnt_q, add_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [31:0]        s1_a_q, s1_a_d;
    logic [31:0]        s1_b_q, s1_b_d;
    logic               s1_valid_q, s1_valid_d;
    logic [63:0]        p_q, p_d;
    logic               p_valid_q, p_valid_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready_s;
    logic               xfer_s;
    logic [63:0]        product_s;
    logic [ACC_W-1:0]   prod_ext_s;
    logic [ACC_W-1:0]   sum_raw_s;
    logic [ACC_W-1:0]   sum_s;
    logic               this_ovf_s;

    wallace_mul_32bit u_mul (
        .a       (s1_a_q),
        .b       (s1_b_q),
        .product (product_s)
    );

    // Ready depends only on state and the input count, never on in_valid.
    assign in_ready_s = (state_q == S_ACC) && (in_cnt_q < BURST_CNT);
    assign xfer_s     = in_valid && in_ready_s;

    // Sign-extend the registered product and form the sum. Overflow is flagged
    // when both addends share a sign that the sum does not.
    always_comb begin
        prod_ext_s = ACC_W'($signed(p_q));
        sum_raw_s  = acc_q + prod_ext_s;
        this_ovf_s = (acc_q[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                     (sum_raw_s[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef DPACC_SAT_EN
        if (this_ovf_s) begin
            // The sign of the accumulator tells positive from negative overflow.
            sum_s = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum_s = sum_raw_s;
        end
`else
        sum_s = sum_raw_s;
`endif
    end

    // Next-state logic for the pipeline registers, the accumulator and the ACC/HOLD FSM.
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        add_cnt_d   = add_cnt_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_valid_d  = xfer_s;
        p_d         = p_q;
        p_valid_d   = s1_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (xfer_s) begin
            s1_a_d   = op_a;
            s1_b_d   = op_b;
            in_cnt_d = in_cnt_q + 8'd1;
        end else begin
            in_cnt_d = in_cnt_q;
        end

        // The product register breaks the path from the multiplier tree to the adder.
        if (s1_valid_q) begin
            p_d = product_s;
        end else begin
            p_d = p_q;
        end

        case (state_q)
            S_ACC: begin
                if (p_valid_q) begin
                    add_cnt_d = add_cnt_q + 8'd1;
                    if (add_cnt_q == LAST_IDX) begin
                        result_d    = sum_s;
                        ovf_d       = ovf_acc_q | this_ovf_s;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                        acc_d       = {ACC_W{1'b0}};
                        ovf_acc_d   = 1'b0;
                    end else begin
                        acc_d     = sum_s;
                        ovf_acc_d = ovf_acc_q | this_ovf_s;
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            S_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_cnt_d    = 8'd0;
                    add_cnt_d   = 8'd0;
                    state_d     = S_ACC;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    // State register with synchronous reset. A partial burst is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACC;
            in_cnt_q    <= 8'd0;
            add_cnt_q   <= 8'd0;
            acc_q       <= {ACC_W{1'b0}};
            ovf_acc_q   <= 1'b0;
            s1_a_q      <= 32'd0;
            s1_b_q      <= 32'd0;
            s1_valid_q  <= 1'b0;
            p_q         <= 64'd0;
            p_valid_q   <= 1'b0;
            result_q    <= {ACC_W{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            add_cnt_q   <= add_cnt_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_valid_q  <= s1_valid_d;
            p_q         <= p_d;
            p_valid_q   <= p_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_dot_product_acc.sv
// Directed testbench for dot_product_acc.
// dut uses BURST_LEN=4 and dut1 uses BURST_LEN=1 with out_ready tied high.
// The expected overflow result follows DPACC_SAT_EN when that macro is defined.
module tb_dot_product_acc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, ovf;
    logic [31:0] op_a, op_b;
    logic [63:0] result;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, ovf1;
    logic [31:0] op_a1, op_b1;
    logic [63:0] result1;
    int          checks = 0;
    int          failures = 0;

    dot_product_acc #(.BURST_LEN(4), .ACC_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf)
    );

    dot_product_acc #(.BURST_LEN(1), .ACC_W(64)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    // Present one pair to dut and hold it until it transfers (bounded wait).
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("send_ready_timeout", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check(tag, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] bl1_a [2];
        logic [31:0] bl1_b [2];
        logic [63:0] bl1_r [2];
        bl1_a[0] = -32'sd90; bl1_b[0] = -32'sd90; bl1_r[0] = 64'd8100;
        bl1_a[1] = 32'sd7;   bl1_b[1] = -32'sd6;  bl1_r[1] = -64'sd42;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = 32'd0; op_b = 32'd0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; op_a1 = 32'd0; op_b1 = 32'd0;
        tick();
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        tick();

        // Mixed-sign burst, back to back: -60 + 6776 + 8100 - 9900 = 4916.
        send(32'sd20, -32'sd3);
        send(32'sd77, 32'sd88);
        send(-32'sd90, -32'sd90);
        send(-32'sd100, 32'sd99);
        check("mix_lat_t0", {63'd0, out_valid}, 64'd0);
        check("mix_in_ready_full", {63'd0, in_ready}, 64'd0);
        tick();
        check("mix_lat_t1", {63'd0, out_valid}, 64'd0);
        tick();
        check("mix_lat_t2", {63'd0, out_valid}, 64'd1);
        check("mix_result", result, 64'd4916);
        check("mix_ovf", {63'd0, ovf}, 64'd0);
        drain();
        check("mix_drain_valid", {63'd0, out_valid}, 64'd0);
        check("mix_drain_ready", {63'd0, in_ready}, 64'd1);

        // Bubbles: 0 + 98765 - 801600 + 246642 = -456193.
        send(32'sd0, 32'sd98765);
        idle(1);
        send(32'sd1, 32'sd98765);
        idle(3);
        send(-32'sd200, 32'sd4008);
        send(-32'sd111, -32'sd2222);
        wait_out("bub_valid");
        check("bub_result", result, -64'sd456193);
        check("bub_ovf", {63'd0, ovf}, 64'd0);

        // Backpressure: hold the result for 5 cycles while a pair is offered.
        op_a = 32'sd9; op_b = 32'sd9; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_result", result, -64'sd456193);
            check("bp_ovf", {63'd0, ovf}, 64'd0);
        end
        in_valid = 1'b0;
        drain();
        check("bp_drain_valid", {63'd0, out_valid}, 64'd0);
        check("bp_drain_ready", {63'd0, in_ready}, 64'd1);

        // Overflow: four products of 2^62 each.
        for (int i = 0; i < 4; i++) send(32'h8000_0000, 32'h8000_0000);
        wait_out("ovf_valid");
`ifdef DPACC_SAT_EN
        check("ovf_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
`else
        check("ovf_result", result, 64'd0);
`endif
        check("ovf_flag", {63'd0, ovf}, 64'd1);
        drain();

        // Reset mid-burst: the partial burst is discarded.
        send(32'sd5, 32'sd5);
        send(32'sd5, 32'sd5);
        rst = 1'b1;
        tick();
        check("rstm_valid_during", {63'd0, out_valid}, 64'd0);
        rst = 1'b0;
        tick();
        check("rstm_valid_after", {63'd0, out_valid}, 64'd0);
        check("rstm_in_ready", {63'd0, in_ready}, 64'd1);
        idle(2);
        check("rstm_valid_later", {63'd0, out_valid}, 64'd0);
        for (int i = 0; i < 4; i++) send(32'sd1, 32'sd1);
        wait_out("rstm_res_valid");
        check("rstm_result", result, 64'd4);
        check("rstm_ovf", {63'd0, ovf}, 64'd0);
        drain();

        // BURST_LEN=1 with out_ready tied high.
        for (int k = 0; k < 2; k++) begin
            op_a1 = bl1_a[k]; op_b1 = bl1_b[k]; in_valid1 = 1'b1;
            check("bl1_ready_pre", {63'd0, in_ready1}, 64'd1);
            tick();
            in_valid1 = 1'b0;
            check("bl1_ready_t0", {63'd0, in_ready1}, 64'd0);
            tick();
            check("bl1_valid_t1", {63'd0, out_valid1}, 64'd0);
            check("bl1_ready_t1", {63'd0, in_ready1}, 64'd0);
            tick();
            check("bl1_valid_t2", {63'd0, out_valid1}, 64'd1);
            check("bl1_ready_t2", {63'd0, in_ready1}, 64'd0);
            check("bl1_result", result1, bl1_r[k]);
            check("bl1_ovf", {63'd0, ovf1}, 64'd0);
            tick();
            check("bl1_valid_t3", {63'd0, out_valid1}, 64'd0);
            check("bl1_ready_t3", {63'd0, in_ready1}, 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
